shiftbram_ctrl: RTL and testbench

SHIFTBRAM_CTRL -- requirements
Module: shiftbram_ctrl

---
 rtl/shiftbram_ctrl.sv | 152 +++++++++++++++
 tb/tb_shiftbram_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftbram_ctrl.sv
// Sequences an external tapped shift register: fills it, emits one window per shift, drains with zeros.
// Windows are valid one cycle after the shift; taps never advance while a window is held by out_ready=0.
module shiftbram_ctrl #(
    parameter int DATA_ = 8,
    parameter int ADDR_ = 1,
    parameter int LINE_ = 4,
    parameter int PAD_  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATA_-1:0] in_data,
    input  logic             in_last,
    output logic             sr_ena,
    output logic [DATA_-1:0] sr_din,
    output logic             sr_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_short
);

    localparam int NT    = 2 ** ADDR_;
    localparam int DEPTH = NT * LINE_;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] PAD_C   = CW'(PAD_);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] pad_cnt, pad_nxt;
    logic          out_valid_nxt;
    logic          err_nxt;
    logic          accept;
    logic          drain_shift;
    logic          clr_req;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pad_nxt       = pad_cnt;
        err_nxt       = 1'b0;
        clr_req       = 1'b0;
        in_ready      = 1'b0;
        out_valid_nxt = out_valid;

        case (state)
            IDLE, FILL: in_ready = 1'b1;
            RUN:        in_ready = !out_valid || out_ready;
            default:    in_ready = 1'b0;
        endcase
        if (rst) in_ready = 1'b0;

        accept      = in_valid && in_ready;
        drain_shift = !rst && (state == DRAIN) && (pad_cnt != '0) && (!out_valid || out_ready);
        sr_ena      = accept || drain_shift;
        sr_din      = accept ? in_data : '0;

        // A consumed window drops unless a shift this cycle refills it.
        if (out_valid && out_ready) out_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (DEPTH == 1) begin
                        out_valid_nxt = 1'b1;
                        cnt_nxt       = DEPTH_C;
                        if (!in_last)       state_nxt = RUN;
                        else if (PAD_ == 0) begin
                            cnt_nxt = '0;
                            clr_req = 1'b1;
                        end else begin
                            state_nxt = DRAIN;
                            pad_nxt   = PAD_C;
                        end
                    end else if (in_last) begin
                        err_nxt = 1'b1;
                        clr_req = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = FILL;
                        cnt_nxt   = ONE_C;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    if (in_last) begin
                        err_nxt   = 1'b1;
                        clr_req   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (cnt == LAST_C) begin
                        state_nxt     = RUN;
                        cnt_nxt       = DEPTH_C;
                        out_valid_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + ONE_C;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    out_valid_nxt = 1'b1;
                    if (in_last) begin
                        if (PAD_ == 0) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                            clr_req   = 1'b1;
                        end else begin
                            state_nxt = DRAIN;
                            pad_nxt   = PAD_C;
                        end
                    end
                end
            end
            default: begin
                if (drain_shift) begin
                    pad_nxt       = pad_cnt - ONE_C;
                    out_valid_nxt = 1'b1;
                end else if (pad_cnt == '0 && (!out_valid || out_ready)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    clr_req   = 1'b1;
                end
            end
        endcase

        sr_clr = rst || clr_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pad_cnt   <= '0;
            out_valid <= 1'b0;
            err_short <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pad_cnt   <= pad_nxt;
            out_valid <= out_valid_nxt;
            err_short <= err_nxt;
        end
    end

endmodule

// File: tb/tb_shiftbram_ctrl.sv
// Directed bench for shiftbram_ctrl at DATA_=8, ADDR_=1, LINE_=4, PAD_=2 (DEPTH=8).
module tb_shiftbram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       sr_ena;
    logic [7:0] sr_din;
    logic       sr_clr;
    logic       out_valid;
    logic       out_ready;
    logic       err_short;

    int total = 0;
    int bad   = 0;
    int win_cnt, clr_cnt, err_cnt, pad_cnt, pad_nz, ov_cnt;
    logic       last_ena;
    logic [7:0] last_din;

    shiftbram_ctrl #(.DATA_(8), .ADDR_(1), .LINE_(4), .PAD_(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .sr_ena    (sr_ena),
        .sr_din    (sr_din),
        .sr_clr    (sr_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_short (err_short)
    );

    always #5 clk = ~clk;

    // Event tallies, one sample per cycle away from the active edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) win_cnt++;
        if (out_valid) ov_cnt++;
        if (sr_clr) clr_cnt++;
        if (err_short) err_cnt++;
        if (sr_ena && !in_ready && !rst) begin
            pad_cnt++;
            if (sr_din !== 8'd0) pad_nz++;
        end
    end

    task automatic clr_counts();
        win_cnt = 0; clr_cnt = 0; err_cnt = 0; pad_cnt = 0; pad_nz = 0; ov_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, output int waited);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waited   = 0;
        #1;
        while (!in_ready && waited < 20) begin
            step();
            #1;
            waited++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_accept word=%0d in_ready=%b want 1", d, in_ready);
        end
        last_ena = sr_ena;
        last_din = sr_din;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        step();
        while (!(in_ready && !out_valid) && n < 20) begin
            step();
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL wait_idle in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0; out_ready = 1'b1;
        step();
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (sr_ena !== 1'b0) begin bad++; $display("FAIL rst_sr_ena got=%b want=0", sr_ena); end
        total++; if (sr_clr !== 1'b1) begin bad++; $display("FAIL rst_sr_clr got=%b want=1", sr_clr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (err_short !== 1'b0) begin bad++; $display("FAIL rst_err_short got=%b want=0", err_short); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (sr_clr !== 1'b0) begin bad++; $display("FAIL idle_sr_clr got=%b want=0", sr_clr); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
        step();
    endtask

    task automatic test_prime();
        int w;
        clr_counts();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b0, w);
            total++;
            if (out_valid !== (i == 8)) begin
                bad++; $display("FAIL prime_out_valid word=%0d got=%b want=%b", i, out_valid, (i == 8));
            end
            if (i == 3) begin
                total++;
                if (last_ena !== 1'b1 || last_din !== 8'd3) begin
                    bad++; $display("FAIL prime_sr_din got ena=%b din=%0d want ena=1 din=3", last_ena, last_din);
                end
            end
        end
        total++; if (win_cnt !== 0) begin bad++; $display("FAIL prime_windows_before got=%0d want=0", win_cnt); end
    endtask

    task automatic test_throughput();
        int w;
        for (int i = 9; i <= 12; i++) begin
            send(8'(i), (i == 12), w);
            total++;
            if (w !== 0 || out_valid !== 1'b1) begin
                bad++; $display("FAIL tput_b2b word=%0d got wait=%0d ov=%b want wait=0 ov=1", i, w, out_valid);
            end
        end
        wait_idle();
        total++; if (win_cnt !== 7) begin bad++; $display("FAIL tput_windows got=%0d want=7", win_cnt); end
        total++; if (pad_cnt !== 2) begin bad++; $display("FAIL tput_pad_shifts got=%0d want=2", pad_cnt); end
        total++; if (pad_nz !== 0) begin bad++; $display("FAIL tput_pad_zero got=%0d nonzero want=0", pad_nz); end
        total++; if (clr_cnt !== 1) begin bad++; $display("FAIL tput_sr_clr got=%0d want=1", clr_cnt); end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL tput_err got=%0d want=0", err_cnt); end
    endtask

    task automatic test_backpressure();
        int w;
        int w0;
        clr_counts();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, w);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd9; in_last = 1'b1;
        w0 = win_cnt;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (in_ready !== 1'b0 || sr_ena !== 1'b0 || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold cyc=%0d got rdy=%b ena=%b ov=%b want 0/0/1", k, in_ready, sr_ena, out_valid);
            end
            step();
        end
        total++; if (win_cnt !== w0) begin bad++; $display("FAIL bp_windows got=%0d want=%0d", win_cnt, w0); end
        out_ready = 1'b1;
        send(8'd9, 1'b1, w);
        total++; if (w !== 0) begin bad++; $display("FAIL bp_resume_wait got=%0d want=0", w); end
        wait_idle();
        total++; if (win_cnt !== w0 + 4) begin bad++; $display("FAIL bp_total_windows got=%0d want=%0d", win_cnt, w0 + 4); end
        total++; if (clr_cnt !== 1) begin bad++; $display("FAIL bp_sr_clr got=%0d want=1", clr_cnt); end
    endtask

    task automatic test_short();
        int w;
        clr_counts();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, w);
        send(8'd5, 1'b1, w);
        total++; if (last_ena !== 1'b1) begin bad++; $display("FAIL short_shifted got=%b want=1", last_ena); end
        total++; if (err_short !== 1'b1) begin bad++; $display("FAIL short_err got=%b want=1", err_short); end
        total++; if (clr_cnt !== 1) begin bad++; $display("FAIL short_sr_clr got=%0d want=1", clr_cnt); end
        step();
        total++; if (err_short !== 1'b0) begin bad++; $display("FAIL short_err_pulse got=%b want=0", err_short); end
        total++; if (err_cnt !== 1) begin bad++; $display("FAIL short_err_count got=%0d want=1", err_cnt); end
        total++; if (ov_cnt !== 0) begin bad++; $display("FAIL short_no_window got=%0d want=0", ov_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL short_idle got=%b want=1", in_ready); end
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b0, w);
            total++;
            if (out_valid !== (i == 8)) begin
                bad++; $display("FAIL short_reprime word=%0d got=%b want=%b", i, out_valid, (i == 8));
            end
        end
        send(8'd9, 1'b1, w);
        wait_idle();
    endtask

    task automatic test_midreset();
        int w;
        clr_counts();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) send(8'(i), 1'b0, w);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'd11;
        #1;
        total++; if (sr_clr !== 1'b1) begin bad++; $display("FAIL mr_sr_clr got=%b want=1", sr_clr); end
        total++; if (in_ready !== 1'b0 || sr_ena !== 1'b0) begin
            bad++; $display("FAIL mr_block got rdy=%b ena=%b want 0/0", in_ready, sr_ena);
        end
        step();
        rst = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_out_valid got=%b want=0", out_valid); end
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b0, w);
            if (i == 1) begin
                total++; if (w !== 0) begin bad++; $display("FAIL mr_first_accept got wait=%0d want=0", w); end
            end
            total++;
            if (out_valid !== (i == 8)) begin
                bad++; $display("FAIL mr_reprime word=%0d got=%b want=%b", i, out_valid, (i == 8));
            end
        end
        send(8'd9, 1'b1, w);
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_prime();
        test_throughput();
        test_backpressure();
        test_short();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded bound");
        $fatal(1);
    end

endmodule
